// File: rtl/cart_bus_front.sv
// Cartridge-side bus front end.
//
// Purpose: demultiplexes the 68k address (j/js) and fix-layer address (f/fs)
// from two CPLD-multiplexed 16-bit buses, converts 68k ROM/port strobes into
// word requests toward the memory switch, drives the 68k data transceiver,
// and fetches fix tile words that are streamed out as bytes.
//
// Ports:
//   clk, rst                  sole clock, synchronous active-high reset
//   j/js, f/fs                multiplexed address buses and their selects
//   as, rw, romoe.., portwe.. asynchronous active-low 68k strobes
//   clk4mb, clk68k            unused
//   d68k, d68kdir, d68koel/h  68k data bus and transceiver control
//   m68kreq/addr/wdata/wr     68k word request toward memory
//   m68kack, m68krdata        one-cycle completion and read data
//   load, half, even, pck1b,
//   pck2b, sa3                asynchronous fix/video timing (even, pck1b unused)
//   msreq/msaddr, msack/msdata fix word request and completion
//   dsreq, dsdata             one-cycle fix byte strobe and byte
//   dbg_state                 {68k fsm[2:0], fix fsm[1:0], j capture[1:0],
//                              f capture[1:0]}; every field is 0 in IDLE
//
// Handshake (both m68k and ms sides): req rises with address/data stable and
// holds them unchanged until the one-cycle ack is sampled; req is low the
// cycle after ack. Read data is only valid in the ack cycle.

// Address capture engine: sel=1 for SETTLE cycles, sample low word, sel=2 for
// SETTLE cycles, sample the HW low bits of the high phase, sel back to 0, then
// a one-cycle done pulse.
module cart_bus_capture #(
    parameter int SETTLE = 4,
    parameter int HW     = 1
) (
    input  logic           clk,
    input  logic           rst,
    input  logic           start_i,
    input  logic [15:0]    bus_i,
    output logic [1:0]     sel_o,
    output logic           done_o,
    output logic [HW+15:0] result_o,
    output logic [1:0]     state_o
);
    typedef enum logic [1:0] {
        C_IDLE = 2'd0,
        C_LOW  = 2'd1,
        C_HIGH = 2'd2,
        C_FIN  = 2'd3
    } cap_state_e;

    localparam int CW = (SETTLE > 1) ? $clog2(SETTLE) : 1;
    localparam logic [CW-1:0] LAST = CW'(SETTLE - 1);

    cap_state_e    state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [15:0]   low_q, low_d;
    logic [HW-1:0] high_q, high_d;
    logic          done_q, done_d;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= C_IDLE;
            cnt_q   <= '0;
            low_q   <= '0;
            high_q  <= '0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            low_q   <= low_d;
            high_q  <= high_d;
            done_q  <= done_d;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        low_d   = low_q;
        high_d  = high_q;
        done_d  = 1'b0;
        unique case (state_q)
            C_IDLE: begin
                if (start_i) begin
                    state_d = C_LOW;
                    cnt_d   = '0;
                end
            end
            C_LOW: begin
                if (cnt_q == LAST) begin
                    low_d   = bus_i;
                    cnt_d   = '0;
                    state_d = C_HIGH;
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            C_HIGH: begin
                if (cnt_q == LAST) begin
                    high_d  = bus_i[HW-1:0];
                    cnt_d   = '0;
                    state_d = C_FIN;
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            C_FIN: begin
                // Select is already back at 0; done follows one cycle later.
                state_d = C_IDLE;
                done_d  = 1'b1;
            end
            default: state_d = C_IDLE;
        endcase
    end

    always_comb begin
        sel_o = 2'd0;
        if (state_q == C_LOW)  sel_o = 2'd1;
        if (state_q == C_HIGH) sel_o = 2'd2;
    end

    assign done_o   = done_q;
    assign result_o = {high_q, low_q};
    assign state_o  = state_q;
endmodule

module cart_bus_front #(
    parameter int SETTLE = 4  // cycles between changing a select and sampling (>= 1)
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [15:0] j,
    output logic [1:0]  js,
    input  logic [15:0] f,
    output logic [1:0]  fs,
    input  logic        as,
    input  logic        rw,
    input  logic        romoe,
    input  logic        romoel,
    input  logic        romoeu,
    input  logic        portadrs,
    input  logic        portoel,
    input  logic        portoeu,
    input  logic        portwel,
    input  logic        portweu,
    input  logic        clk4mb,
    input  logic        clk68k,
    inout  wire  [15:0] d68k,
    output logic        d68kdir,
    output logic        d68koel,
    output logic        d68koeh,
    output logic        m68kreq,
    output logic [19:0] m68kaddr,
    output logic [15:0] m68kwdata,
    output logic        m68kwr,
    input  logic        m68kack,
    input  logic [15:0] m68krdata,
    input  logic        load,
    input  logic        half,
    input  logic        even,
    input  logic        pck1b,
    input  logic        pck2b,
    input  logic        sa3,
    output logic        msreq,
    output logic [16:0] msaddr,
    input  logic        msack,
    input  logic [15:0] msdata,
    output logic        dsreq,
    output logic [7:0]  dsdata,
    output logic [8:0]  dbg_state
);
    typedef enum logic [2:0] {
        M_IDLE  = 3'd0,
        M_CAPT  = 3'd1,
        M_MREQ  = 3'd2,
        M_DRIVE = 3'd3
    } m68k_state_e;

    typedef enum logic [1:0] {
        F_IDLE = 2'd0,
        F_CAPT = 2'd1,
        F_REQ  = 2'd2
    } fix_state_e;

    logic unused_pins;
    assign unused_pins = ^{as, clk4mb, clk68k, even, pck1b};

    // ---------------- synchronisers and edge detection ----------------
    // Not reset: after reset a strobe that is still held low must not look
    // like a fresh edge.
    logic [12:0] sync1_q, sync2_q;
    logic        rd_n_prev_q, wr_n_prev_q, pck_prev_q, load_prev_q;
    logic        rw_s, romoe_s, romoel_s, romoeu_s, portadrs_s, portoel_s, portoeu_s;
    logic        portwel_s, portweu_s, load_s, half_s, pck2b_s, sa3_s;
    logic        rd_n, wr_n, rd_start, wr_start, pck_rise, load_rise;

    always_ff @(posedge clk) begin
        sync1_q     <= {rw, romoe, romoel, romoeu, portadrs, portoel, portoeu,
                        portwel, portweu, load, half, pck2b, sa3};
        sync2_q     <= sync1_q;
        rd_n_prev_q <= rd_n;
        wr_n_prev_q <= wr_n;
        pck_prev_q  <= pck2b_s;
        load_prev_q <= load_s;
    end

    assign {rw_s, romoe_s, romoel_s, romoeu_s, portadrs_s, portoel_s, portoeu_s,
            portwel_s, portweu_s, load_s, half_s, pck2b_s, sa3_s} = sync2_q;

    assign rd_n = romoe_s & portadrs_s;   // low while any read space is selected
    assign wr_n = portwel_s & portweu_s;  // low while any write lane is active

    // rw qualifies read starts so that portadrs falling ahead of a port write
    // is not mistaken for a port read.
    assign rd_start  = rd_n_prev_q & ~rd_n & rw_s;
    assign wr_start  = wr_n_prev_q & ~wr_n & ~portadrs_s;
    assign pck_rise  = pck2b_s & ~pck_prev_q;
    assign load_rise = load_s & ~load_prev_q;

    // ---------------- capture engines ----------------
    logic        j_start, j_done, f_start, f_done;
    logic [18:0] j_cap;
    logic [16:0] f_cap;
    logic [1:0]  j_cstate, f_cstate;

    cart_bus_capture #(.SETTLE(SETTLE), .HW(3)) u_jcap (
        .clk(clk), .rst(rst), .start_i(j_start), .bus_i(j), .sel_o(js),
        .done_o(j_done), .result_o(j_cap), .state_o(j_cstate)
    );

    cart_bus_capture #(.SETTLE(SETTLE), .HW(1)) u_fcap (
        .clk(clk), .rst(rst), .start_i(f_start), .bus_i(f), .sel_o(fs),
        .done_o(f_done), .result_o(f_cap), .state_o(f_cstate)
    );

    // ---------------- 68k path ----------------
    m68k_state_e m_state_q, m_state_d;
    logic        is_port_q, is_port_d, is_wr_q, is_wr_d;
    logic        lane_lo_q, lane_lo_d, lane_hi_q, lane_hi_d;
    logic        abort_q, abort_d, wr_en_q, wr_en_d, wr_q, wr_d;
    logic [19:0] addr_q, addr_d;
    logic [15:0] wdata_q, wdata_d, dout_q, dout_d;

    // ---------------- fix path ----------------
    fix_state_e  f_state_q, f_state_d;
    logic [16:0] msaddr_q, msaddr_d;
    logic [15:0] tile_q, tile_d;
    logic        dsreq_q, dsreq_d;
    logic [7:0]  dsdata_q, dsdata_d;

    always_ff @(posedge clk) begin
        if (rst) begin
            m_state_q <= M_IDLE;
            is_port_q <= 1'b0;
            is_wr_q   <= 1'b0;
            lane_lo_q <= 1'b0;
            lane_hi_q <= 1'b0;
            abort_q   <= 1'b0;
            wr_en_q   <= 1'b0;
            wr_q      <= 1'b0;
            addr_q    <= '0;
            wdata_q   <= '0;
            dout_q    <= '0;
            f_state_q <= F_IDLE;
            msaddr_q  <= '0;
            tile_q    <= '0;
            dsreq_q   <= 1'b0;
            dsdata_q  <= '0;
        end else begin
            m_state_q <= m_state_d;
            is_port_q <= is_port_d;
            is_wr_q   <= is_wr_d;
            lane_lo_q <= lane_lo_d;
            lane_hi_q <= lane_hi_d;
            abort_q   <= abort_d;
            wr_en_q   <= wr_en_d;
            wr_q      <= wr_d;
            addr_q    <= addr_d;
            wdata_q   <= wdata_d;
            dout_q    <= dout_d;
            f_state_q <= f_state_d;
            msaddr_q  <= msaddr_d;
            tile_q    <= tile_d;
            dsreq_q   <= dsreq_d;
            dsdata_q  <= dsdata_d;
        end
    end

    always_comb begin
        m_state_d = m_state_q;
        is_port_d = is_port_q;
        is_wr_d   = is_wr_q;
        lane_lo_d = lane_lo_q;
        lane_hi_d = lane_hi_q;
        abort_d   = abort_q;
        wr_en_d   = wr_en_q & ~wr_n;  // transceiver stays open until write strobes rise
        wr_d      = wr_q;
        addr_d    = addr_q;
        wdata_d   = wdata_q;
        dout_d    = dout_q;
        j_start   = 1'b0;
        unique case (m_state_q)
            M_IDLE: begin
                if (rd_start) begin
                    m_state_d = M_CAPT;
                    j_start   = 1'b1;
                    is_port_d = romoe_s;
                    is_wr_d   = 1'b0;
                    wr_d      = 1'b0;
                    abort_d   = 1'b0;
                    lane_lo_d = romoe_s ? ~portoel_s : ~romoel_s;
                    lane_hi_d = romoe_s ? ~portoeu_s : ~romoeu_s;
                end else if (wr_start) begin
                    m_state_d = M_CAPT;
                    j_start   = 1'b1;
                    is_port_d = 1'b1;
                    is_wr_d   = 1'b1;
                    wr_d      = 1'b1;
                    abort_d   = 1'b0;
                    wr_en_d   = 1'b1;
                    wdata_d   = d68k;
                end
            end
            M_CAPT: begin
                // A read whose strobe goes away still completes, but its data
                // is never put on the bus.
                abort_d = abort_q | (~is_wr_q & rd_n);
                if (j_done) begin
                    m_state_d = M_MREQ;
                    addr_d    = {is_port_q, j_cap};
                end
            end
            M_MREQ: begin
                abort_d = abort_q | (~is_wr_q & rd_n);
                if (m68kack) begin
                    wr_d = 1'b0;
                    if (is_wr_q || abort_d) begin
                        m_state_d = M_IDLE;
                    end else begin
                        m_state_d = M_DRIVE;
                        dout_d    = m68krdata;
                    end
                end
            end
            M_DRIVE: begin
                if (rd_n) m_state_d = M_IDLE;
            end
            default: m_state_d = M_IDLE;
        endcase
    end

    always_comb begin
        f_state_d = f_state_q;
        msaddr_d  = msaddr_q;
        tile_d    = tile_q;
        f_start   = 1'b0;
        dsreq_d   = load_rise;
        dsdata_d  = dsdata_q;
        if (load_rise) dsdata_d = half_s ? tile_q[15:8] : tile_q[7:0];
        unique case (f_state_q)
            F_IDLE: begin
                if (pck_rise) begin
                    f_state_d = F_CAPT;
                    f_start   = 1'b1;
                end
            end
            F_CAPT: begin
                if (f_done) begin
                    f_state_d = F_REQ;
                    msaddr_d  = {f_cap[16:4], sa3_s, f_cap[2:0]};
                end
            end
            F_REQ: begin
                if (msack) begin
                    f_state_d = F_IDLE;
                    tile_d    = msdata;
                end
            end
            default: f_state_d = F_IDLE;
        endcase
    end

    logic drive;
    assign drive     = (m_state_q == M_DRIVE);
    assign d68k      = drive ? dout_q : 'z;
    assign d68kdir   = drive;
    assign d68koel   = ~((drive & lane_lo_q) | wr_en_q);
    assign d68koeh   = ~((drive & lane_hi_q) | wr_en_q);
    assign m68kreq   = (m_state_q == M_MREQ);
    assign m68kaddr  = addr_q;
    assign m68kwdata = wdata_q;
    assign m68kwr    = wr_q;
    assign msreq     = (f_state_q == F_REQ);
    assign msaddr    = msaddr_q;
    assign dsreq     = dsreq_q;
    assign dsdata    = dsdata_q;
    assign dbg_state = {m_state_q, f_state_q, j_cstate, f_cstate};
endmodule

// File: tb/tb_cart_bus_front.sv
module tb_cart_bus_front;
    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    // ---------------- DUT signals ----------------
    logic [15:0] j, f;
    logic [1:0]  js, fs;
    logic        as_n, rw, romoe, romoel, romoeu, portadrs, portoel, portoeu;
    logic        portwel, portweu, clk4mb, clk68k;
    wire  [15:0] d68k;
    logic        d68kdir, d68koel, d68koeh;
    logic        m68kreq, m68kwr, m68kack;
    logic [19:0] m68kaddr;
    logic [15:0] m68kwdata, m68krdata;
    logic        load, half, even, pck1b, pck2b, sa3;
    logic        msreq, msack, dsreq;
    logic [16:0] msaddr;
    logic [15:0] msdata;
    logic [7:0]  dsdata;
    logic [8:0]  dbg_state;

    // Bench-side bus sources: phase values presented according to the select.
    logic [15:0] j_lo, j_hi, f_lo, f_hi;
    logic [15:0] tb_d;
    logic        tb_d_en;
    assign d68k = tb_d_en ? tb_d : 'z;

    always_comb begin
        j = 16'hDEAD;
        if (js == 2'd1) j = j_lo;
        if (js == 2'd2) j = j_hi;
        f = 16'hC0DE;
        if (fs == 2'd1) f = f_lo;
        if (fs == 2'd2) f = f_hi;
    end

    cart_bus_front #(.SETTLE(4)) dut (
        .clk(clk), .rst(rst), .j(j), .js(js), .f(f), .fs(fs),
        .as(as_n), .rw(rw), .romoe(romoe), .romoel(romoel), .romoeu(romoeu),
        .portadrs(portadrs), .portoel(portoel), .portoeu(portoeu),
        .portwel(portwel), .portweu(portweu), .clk4mb(clk4mb), .clk68k(clk68k),
        .d68k(d68k), .d68kdir(d68kdir), .d68koel(d68koel), .d68koeh(d68koeh),
        .m68kreq(m68kreq), .m68kaddr(m68kaddr), .m68kwdata(m68kwdata),
        .m68kwr(m68kwr), .m68kack(m68kack), .m68krdata(m68krdata),
        .load(load), .half(half), .even(even), .pck1b(pck1b), .pck2b(pck2b),
        .sa3(sa3), .msreq(msreq), .msaddr(msaddr), .msack(msack),
        .msdata(msdata), .dsreq(dsreq), .dsdata(dsdata), .dbg_state(dbg_state)
    );

    // ---------------- model and scoreboard ----------------
    int checks   = 0;
    int failures = 0;

    logic [19:0] exp_addr;
    logic        exp_wr;
    logic [15:0] exp_wdata;
    logic [15:0] exp_rdata;
    logic        exp_lo, exp_hi;
    logic        allow_drive, allow_wr;
    logic [16:0] exp_ms_addr;
    logic [7:0]  exp_q[$];

    function automatic logic [19:0] m68k_addr_model(input logic port, input logic [15:0] hi,
                                                    input logic [15:0] lo);
        return {port, hi[2:0], lo};
    endfunction

    function automatic logic [16:0] fix_addr_model(input logic [15:0] hi, input logic [15:0] lo,
                                                   input logic s3);
        logic [16:0] a;
        a    = {hi[0], lo};
        a[3] = s3;
        return a;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h expected=%h at %0t", name, act, exp, $time);
        end
    endtask

    // Compare process: every cycle the outputs mean something, hold them to the model.
    always @(negedge clk) begin
        if (!rst) begin
            if (m68kreq) begin
                check("m68kaddr", {12'd0, m68kaddr}, {12'd0, exp_addr});
                check("m68kwr", {31'd0, m68kwr}, {31'd0, exp_wr});
                if (exp_wr) check("m68kwdata", {16'd0, m68kwdata}, {16'd0, exp_wdata});
            end
            if (msreq) check("msaddr", {15'd0, msaddr}, {15'd0, exp_ms_addr});
            if (dsreq) begin
                if (exp_q.size() == 0) begin
                    checks++;
                    failures++;
                    $display("FAIL dsreq_unexpected actual=1 expected=0 at %0t", $time);
                end else begin
                    logic [7:0] b;
                    b = exp_q.pop_front();
                    check("dsdata_stream", {24'd0, dsdata}, {24'd0, b});
                end
            end
            if (d68kdir) begin
                check("drive_permitted", {31'd0, allow_drive}, 32'd1);
                check("d68k", {16'd0, d68k}, {16'd0, exp_rdata});
                check("lanes", {30'd0, d68koeh, d68koel}, {30'd0, ~exp_hi, ~exp_lo});
            end else if (!allow_wr) begin
                check("idle_enables", {30'd0, d68koeh, d68koel}, 32'd3);
            end
        end
    end

    // ---------------- driver tasks ----------------
    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    function automatic bit cond_met(input int c);
        case (c)
            0: return m68kreq;
            1: return msreq;
            2: return dsreq;
            3: return (!d68kdir && d68koel && d68koeh);
            default: return 1'b0;
        endcase
    endfunction

    task automatic wait_until(input int c, input int limit, input string name);
        int n;
        n = 0;
        while (!cond_met(c) && n < limit) begin
            tick(1);
            n++;
        end
        checks++;
        if (!cond_met(c)) begin
            failures++;
            $display("FAIL %s actual=timeout expected=event within %0d cycles", name, limit);
        end
    endtask

    task automatic pulse_m68kack(input logic [15:0] data);
        m68krdata = data;
        m68kack   = 1'b1;
        tick(1);
        m68kack   = 1'b0;
    endtask

    task automatic pulse_msack(input logic [15:0] data);
        msdata = data;
        msack  = 1'b1;
        tick(1);
        msack  = 1'b0;
    endtask

    task automatic pulse_pck2b();
        pck2b = 1'b1;
        tick(2);
        pck2b = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog actual=running expected=finished");
        $fatal(1, "watchdog");
    end

    // ---------------- directed stimulus ----------------
    initial begin
        bit seen;
        rst = 1'b1;
        as_n = 1'b1; rw = 1'b1; romoe = 1'b1; romoel = 1'b1; romoeu = 1'b1;
        portadrs = 1'b1; portoel = 1'b1; portoeu = 1'b1; portwel = 1'b1; portweu = 1'b1;
        clk4mb = 1'b0; clk68k = 1'b0;
        load = 1'b0; half = 1'b0; even = 1'b0; pck1b = 1'b0; pck2b = 1'b0; sa3 = 1'b0;
        m68kack = 1'b0; m68krdata = '0; msack = 1'b0; msdata = '0;
        tb_d = '0; tb_d_en = 1'b0;
        j_lo = '0; j_hi = '0; f_lo = '0; f_hi = '0;
        exp_addr = '0; exp_wr = 1'b0; exp_wdata = '0; exp_rdata = '0;
        exp_lo = 1'b0; exp_hi = 1'b0; allow_drive = 1'b0; allow_wr = 1'b0;
        exp_ms_addr = '0;
        tick(5);

        // Reset values
        check("rst_js", {30'd0, js}, 32'd0);
        check("rst_fs", {30'd0, fs}, 32'd0);
        check("rst_dir", {31'd0, d68kdir}, 32'd0);
        check("rst_enables", {30'd0, d68koeh, d68koel}, 32'd3);
        check("rst_reqs", {29'd0, m68kreq, msreq, dsreq}, 32'd0);
        check("rst_m68kwr", {31'd0, m68kwr}, 32'd0);
        check("rst_addrs", {m68kaddr, 12'd0} | {15'd0, msaddr}, 32'd0);
        check("rst_data", {m68kwdata, 8'd0, dsdata}, 32'd0);
        rst = 1'b0;
        tick(3);

        // ROM read, both lanes
        j_lo = 16'h1234; j_hi = 16'h0005;
        exp_addr = m68k_addr_model(1'b0, j_hi, j_lo); exp_wr = 1'b0;
        romoe = 1'b0; romoel = 1'b0; romoeu = 1'b0;
        wait_until(0, 40, "rom_req");
        check("rom_addr_literal", {12'd0, m68kaddr}, 32'h51234);
        check("rom_wr", {31'd0, m68kwr}, 32'd0);
        exp_rdata = 16'hBEEF; exp_lo = 1'b1; exp_hi = 1'b1; allow_drive = 1'b1;
        pulse_m68kack(16'hBEEF);
        check("rom_dir_after_ack", {31'd0, d68kdir}, 32'd1);
        check("rom_d68k", {16'd0, d68k}, 32'h0000BEEF);
        check("rom_enables", {30'd0, d68koeh, d68koel}, 32'd0);
        check("rom_req_dropped", {31'd0, m68kreq}, 32'd0);
        tick(3);
        romoe = 1'b1;
        tick(2);
        check("rom_still_driving", {31'd0, d68kdir}, 32'd1);
        tick(1);
        check("rom_released", {29'd0, d68kdir, d68koeh, d68koel}, 32'd3);
        allow_drive = 1'b0;
        romoel = 1'b1; romoeu = 1'b1;
        tick(4);

        // Port byte read, low lane only
        j_lo = 16'h0100; j_hi = 16'h0000;
        exp_addr = m68k_addr_model(1'b1, j_hi, j_lo); exp_wr = 1'b0;
        portadrs = 1'b0; portoel = 1'b0;
        wait_until(0, 40, "port_req");
        check("port_addr_literal", {12'd0, m68kaddr}, 32'h80100);
        exp_rdata = 16'h00C3; exp_lo = 1'b1; exp_hi = 1'b0; allow_drive = 1'b1;
        pulse_m68kack(16'h00C3);
        check("port_lanes", {29'd0, d68kdir, d68koeh, d68koel}, 32'd6);
        portadrs = 1'b1; portoel = 1'b1;
        wait_until(3, 6, "port_release");
        allow_drive = 1'b0;
        tick(3);

        // Port write
        rw = 1'b0;
        tick(3);
        j_lo = 16'h0222; j_hi = 16'h0003;
        exp_addr = m68k_addr_model(1'b1, j_hi, j_lo); exp_wr = 1'b1; exp_wdata = 16'hA55A;
        tb_d = 16'hA55A; tb_d_en = 1'b1;
        portadrs = 1'b0;
        tick(4);
        check("portadrs_alone_no_start", {31'd0, m68kreq}, 32'd0);
        allow_wr = 1'b1;
        portwel = 1'b0; portweu = 1'b0;
        tick(4);
        tb_d = 16'h1111;  // data must have been latched at the start
        check("wr_enables_low", {29'd0, d68kdir, d68koeh, d68koel}, 32'd0);
        wait_until(0, 40, "wr_req");
        check("wr_flag", {31'd0, m68kwr}, 32'd1);
        check("wr_data_literal", {16'd0, m68kwdata}, 32'h0000A55A);
        check("wr_addr", {12'd0, m68kaddr}, 32'hB0222);
        pulse_m68kack(16'h0000);
        check("wr_done_req", {31'd0, m68kreq}, 32'd0);
        check("wr_done_idle", {23'd0, dbg_state}, 32'd0);
        portwel = 1'b1; portweu = 1'b1; portadrs = 1'b1; tb_d_en = 1'b0;
        wait_until(3, 6, "wr_release");
        allow_wr = 1'b0;
        rw = 1'b1;
        tick(3);

        // Fix fetch
        f_lo = 16'h0010; f_hi = 16'h0001; sa3 = 1'b1;
        exp_ms_addr = fix_addr_model(f_hi, f_lo, 1'b1);
        tick(3);
        pulse_pck2b();
        wait_until(1, 40, "fix_req");
        check("fix_addr_literal", {15'd0, msaddr}, 32'h10018);
        pulse_msack(16'h12AB);
        half = 1'b0;
        tick(3);
        exp_q.push_back(8'hAB);
        load = 1'b1;
        tick(3);
        check("ds_latency_lo", {31'd0, dsreq}, 32'd1);
        check("ds_byte_lo", {24'd0, dsdata}, 32'h000000AB);
        tick(1);
        check("ds_one_cycle", {31'd0, dsreq}, 32'd0);
        load = 1'b0; half = 1'b1;
        tick(3);
        exp_q.push_back(8'h12);
        load = 1'b1;
        wait_until(2, 6, "ds_hi");
        check("ds_byte_hi", {24'd0, dsdata}, 32'h00000012);
        load = 1'b0;
        tick(3);

        // Second fetch: pck2b during the outstanding request is ignored
        f_lo = 16'h0F0F; f_hi = 16'h0000; sa3 = 1'b0;
        exp_ms_addr = fix_addr_model(f_hi, f_lo, 1'b0);
        tick(3);
        pulse_pck2b();
        wait_until(1, 40, "fix_req2");
        check("fix_addr2", {15'd0, msaddr}, 32'h00F07);
        pulse_pck2b();
        tick(3);
        pulse_msack(16'h5A3C);
        seen = 1'b0;
        for (int i = 0; i < 25; i++) begin
            if (msreq) seen = 1'b1;
            tick(1);
        end
        check("no_refetch", {31'd0, seen}, 32'd0);
        half = 1'b0;
        tick(3);
        exp_q.push_back(8'h3C);
        load = 1'b1;
        wait_until(2, 6, "ds_tile2");
        load = 1'b0;
        tick(3);

        // Read strobe released during capture: request completes, no drive
        j_lo = 16'h0ABC; j_hi = 16'h0002;
        exp_addr = m68k_addr_model(1'b0, j_hi, j_lo); exp_wr = 1'b0;
        romoe = 1'b0; romoel = 1'b0;
        tick(4);
        romoe = 1'b1;
        wait_until(0, 40, "abort_req");
        check("abort_addr", {12'd0, m68kaddr}, 32'h20ABC);
        pulse_m68kack(16'h7777);
        tick(2);
        check("abort_no_drive", {29'd0, d68kdir, d68koeh, d68koel}, 32'd3);
        check("abort_idle", {29'd0, dbg_state[8:6]}, 32'd0);
        romoel = 1'b1;
        tick(4);

        // Reset while a request is pending
        j_lo = 16'h4444; j_hi = 16'h0006;
        exp_addr = m68k_addr_model(1'b0, j_hi, j_lo); exp_wr = 1'b0;
        romoe = 1'b0; romoel = 1'b0; romoeu = 1'b0;
        wait_until(0, 40, "rst_req");
        rst = 1'b1;
        tick(1);
        check("mid_rst_req", {30'd0, m68kreq, msreq}, 32'd0);
        check("mid_rst_addr", {12'd0, m68kaddr}, 32'd0);
        check("mid_rst_msaddr", {15'd0, msaddr}, 32'd0);
        check("mid_rst_dsdata", {24'd0, dsdata}, 32'd0);
        check("mid_rst_xcvr", {29'd0, d68kdir, d68koeh, d68koel}, 32'd3);
        check("mid_rst_sel", {28'd0, js, fs}, 32'd0);
        tick(1);
        rst = 1'b0;
        pulse_m68kack(16'h9999);
        tick(2);
        check("late_ack_ignored", {29'd0, m68kreq, d68kdir, d68koel}, 32'd1);
        check("late_ack_idle", {23'd0, dbg_state}, 32'd0);
        romoe = 1'b1; romoel = 1'b1; romoeu = 1'b1;
        tick(5);

        check("ds_queue_drained", exp_q.size(), 32'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
